bitserial_mac_ctrl: RTL and testbench
=====================================

Name: bitserial_mac_ctrl

Overview:
Sequencer for the 32-lane bit-serial weight x activation dot-product datapath. Holds the 32 4-bit weights. Accepts one vector of 32 4-bit activations per job and issues four gated-weight bit-planes, MSB first, to the external adder tree. Shift-accumulates the returned partial sums into the 13-bit result and pulses out_valid.

Parameters:
N_LANES, 32, number of lanes (weights/activations per job)
ACT_W, 4, activation width = number of bit-planes issued
WGT_W, 4, weight width
PSUM_W, 9, adder-tree partial-sum width (32*15 = 480 max)
OUT_W, 13, result width (32*15*15 = 7200 max, no overflow)
DP_LAT, 1, adder-tree latency in cycles, lane_valid to psum_in; legal 0..3

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  async active-low reset
wgt_we  in  1  weight write strobe
wgt_addr  in  5  weight lane index
wgt_data  in  WGT_W  weight value
wgt_err  out  1  one-cycle pulse: write dropped because block busy
in_valid  in  1  activation vector valid
in_ready  out  1  block can accept a vector this cycle
in_act  in  N_LANES*ACT_W  activations, lane i at bits [4i+3:4i]
lane_out  out  N_LANES*WGT_W  gated weights to adder tree, lane i = weight[i] & {4{act[i][b]}}
lane_valid  out  1  lane_out holds a live bit-plane
psum_in  in  PSUM_W  adder-tree sum, valid DP_LAT cycles after lane_valid
out_valid  out  1  one-cycle result pulse
Output  out  OUT_W  result, held until next result
busy  out  1  job in flight (state != IDLE)

Behaviour:
- Reset: state IDLE; weights, act register, accumulator, Output = 0. in_ready = 1. lane_valid, out_valid, wgt_err, busy = 0. lane_out = 0.
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- in_ready = (state == IDLE) | (state == DONE).
- IDLE/DONE, accept: in_valid & in_ready. Latch in_act, clear acc, bit index b = 3, go to ISSUE. Call the accept edge cycle 0.
- ISSUE, cycles 1..4: lane_valid = 1, plane b = 3, 2, 1, 0. b decrements each cycle. After b = 0, go to DRAIN if DP_LAT > 0, else DONE.
- Capture: a fixed internal DP_LAT-deep valid shift pipe tags returning sums; psum_in is never self-qualified. For each tagged cycle, acc <= (acc << 1) + psum_in, zero-extended to OUT_W.
- DRAIN: wait until the last tagged sum is captured, at the end of cycle 4+DP_LAT, then go to DONE.
- DONE, cycle 5+DP_LAT: out_valid = 1 and Output = acc, registered. Leave DONE after one cycle: to ISSUE on accept, else to IDLE. Back-to-back jobs therefore have a period of 5+DP_LAT cycles.
- Outside ISSUE: lane_out = 0 and lane_valid = 0.
- Weight writes: applied on the next edge only when state == IDLE. Otherwise dropped and wgt_err pulses the next cycle. Weights are never changed mid-job.
- in_valid while in_ready = 0: ignored, not queued. The source must hold in_valid.
- Reset mid-job: abort immediately to reset values. No out_valid for the aborted job. Weights cleared.
- Latency, DP_LAT = 1: accept at cycle 0, out_valid at cycle 6.

Optional Feature:
Macro ZERO_SKIP_EN.
- Defined: a plane whose 32 activation bits are all 0 is not issued. lane_valid = 0 and lane_out held at its previous value (no toggling). The pipe still tags that slot, and acc shifts with an addend of 0, ignoring psum_in. Result and cycle timing are unchanged.
- Not defined: every plane is issued, lane_valid = 1 for all 4 ISSUE cycles.

Decomposition:
- Package bitserial_mac_pkg holds N_LANES, ACT_W, WGT_W, PSUM_W, OUT_W, and the FSM state enum (2-bit).
- One natural sub-module: bitserial_plane_gate. Combinational; takes the weight bank, the activation register and b, produces lane_out and the all-zero-plane flag.
- FSM, valid pipe and accumulator stay in the top module.

Test Plan:
- Weights all 15, activations all 15, ideal adder-tree model, DP_LAT = 1 -> out_valid at cycle 6, Output = 7200.
- Weights i%16, activations from a seeded $random, 10 back-to-back jobs with in_valid held -> each Output = sum(w*a), out_valid spaced exactly 6 cycles apart.
- wgt_we asserted during ISSUE (lane 5, value 9) -> wgt_err pulse, weight[5] unchanged, result unaffected. Same write in IDLE -> applied, no wgt_err.
- rst_n dropped in cycle 3 of a job -> outputs go to reset values asynchronously, no out_valid, in_ready = 1 after release.
- ZERO_SKIP_EN, activations = 4'b0101 on all lanes, weights = 3 -> lane_valid low in cycles 1 and 3, Output = 480, out_valid still at cycle 6.
- DP_LAT = 0 and DP_LAT = 3 builds, activations = 1, weights = 1 -> Output = 32, out_valid at cycles 5 and 8 respectively.

Source files
------------

// File: rtl/bitserial_mac_pkg.sv
// bitserial_mac_pkg: shared widths and FSM state encoding for the bit-serial MAC sequencer
package bitserial_mac_pkg;
  localparam int N_LANES = 32;
  localparam int ACT_W = 4;
  localparam int WGT_W = 4;
  localparam int PSUM_W = 9;
  localparam int OUT_W = 13;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/bitserial_plane_gate.sv
// bitserial_plane_gate: gates each lane's weight with activation bit b; flags an all-zero plane
module bitserial_plane_gate
  import bitserial_mac_pkg::*;
(
  input  logic [N_LANES*WGT_W-1:0] wgt,
  input  logic [N_LANES*ACT_W-1:0] act,
  input  logic [1:0]               b,
  output logic [N_LANES*WGT_W-1:0] lanes,
  output logic                     zero
);
  logic [N_LANES-1:0] plane;
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic [ACT_W-1:0] a;
    assign a = act[i*ACT_W +: ACT_W];
    assign plane[i] = a[b];
    assign lanes[i*WGT_W +: WGT_W] = wgt[i*WGT_W +: WGT_W] & {WGT_W{plane[i]}};
  end
  assign zero = ~|plane;
endmodule

// File: rtl/bitserial_mac_ctrl.sv
// bitserial_mac_ctrl: issues 4 MSB-first gated-weight bit-planes and shift-accumulates the adder-tree sums.
// Define ZERO_SKIP_EN to suppress issuing all-zero activation planes.
module bitserial_mac_ctrl
  import bitserial_mac_pkg::*;
#(
  parameter int DP_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wgt_we,
  input  logic [4:0]               wgt_addr,
  input  logic [WGT_W-1:0]         wgt_data,
  output logic                     wgt_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_LANES*ACT_W-1:0] in_act,
  output logic [N_LANES*WGT_W-1:0] lane_out,
  output logic                     lane_valid,
  input  logic [PSUM_W-1:0]        psum_in,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         Output,
  output logic                     busy
);
  state_t state, state_nxt;
  logic [N_LANES*WGT_W-1:0] wgt, lanes;
  logic [N_LANES*ACT_W-1:0] act;
  logic [1:0] b;
  logic [OUT_W-1:0] acc, acc_nxt;
  logic issue, accept, zero, skip, tag, tag_last, tag_skip;
  assign issue = state == ISSUE;
  assign in_ready = state == IDLE || state == DONE;
  assign accept = in_valid && in_ready;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  assign lane_valid = issue && !skip;
  bitserial_plane_gate u_gate (
    .wgt(wgt),
    .act(act),
    .b(b),
    .lanes(lanes),
    .zero(zero)
  );
`ifdef ZERO_SKIP_EN
  logic [N_LANES*WGT_W-1:0] lane_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lane_q <= '0;
    else lane_q <= lane_out;
  assign skip = issue && zero;
  assign lane_out = issue ? (zero ? lane_q : lanes) : '0;
`else
  logic unused_zero;
  assign unused_zero = zero;
  assign skip = 1'b0;
  assign lane_out = issue ? lanes : '0;
`endif
  // Returning sums are qualified only by this fixed-depth tag pipe, never by psum_in itself
  if (DP_LAT == 0) begin : g_nopipe
    assign tag = issue;
    assign tag_last = issue && b == 2'd0;
    assign tag_skip = skip;
  end else begin : g_pipe
    logic [DP_LAT-1:0] vld, lst, skp;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {vld, lst, skp} <= '0;
      else begin
        vld[0] <= issue;
        lst[0] <= issue && b == 2'd0;
        skp[0] <= skip;
        for (int k = 1; k < DP_LAT; k++) begin
          vld[k] <= vld[k-1];
          lst[k] <= lst[k-1];
          skp[k] <= skp[k-1];
        end
      end
    assign tag = vld[DP_LAT-1];
    assign tag_last = lst[DP_LAT-1];
    assign tag_skip = skp[DP_LAT-1];
  end
  assign acc_nxt = (acc << 1) + OUT_W'(tag_skip ? {PSUM_W{1'b0}} : psum_in);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? ISSUE : IDLE;
      ISSUE:   state_nxt = b != 2'd0 ? ISSUE : (DP_LAT > 0 ? DRAIN : DONE);
      DRAIN:   state_nxt = tag_last ? DONE : DRAIN;
      DONE:    state_nxt = accept ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wgt <= '0;
      act <= '0;
      acc <= '0;
      b <= 2'd0;
      Output <= '0;
      wgt_err <= 1'b0;
    end else begin
      wgt_err <= wgt_we && state != IDLE;
      if (wgt_we && state == IDLE) wgt[{wgt_addr, 2'b00} +: WGT_W] <= wgt_data;
      if (accept) begin
        act <= in_act;
        acc <= '0;
        b <= 2'd3;
      end else begin
        if (issue) b <= b - 2'd1;
        if (tag) acc <= acc_nxt;
      end
      if (tag_last) Output <= acc_nxt;
    end
endmodule

// File: tb/tb_bitserial_mac_ctrl.sv
// tb_bitserial_mac_ctrl: directed jobs against a dot-product/timing model with an ideal delayed adder tree
module tb_bitserial_mac_ctrl;
  localparam int DP = 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic wgt_we = 1'b0;
  logic [4:0] wgt_addr = '0;
  logic [3:0] wgt_data = '0;
  logic wgt_err, in_ready, lane_valid, out_valid, busy;
  logic in_valid = 1'b0;
  logic [127:0] in_act = '0;
  logic [127:0] lane_out;
  logic [8:0] psum_in;
  logic [12:0] Output;
  always #5 clk = ~clk;
  bitserial_mac_ctrl #(.DP_LAT(DP)) dut (
    .clk(clk), .rst_n(rst_n), .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
    .wgt_err(wgt_err), .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
    .lane_out(lane_out), .lane_valid(lane_valid), .psum_in(psum_in), .out_valid(out_valid),
    .Output(Output), .busy(busy)
  );
  int errors = 0, checks = 0;
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask
  // ideal adder tree: lane sum delayed DP cycles; junk whenever the delayed slot was not live
  int lsum;
  logic [9:0] cur;
  logic [9:0] dl [1:3] = '{default: '0};
  logic [8:0] junk = '0;
  logic [9:0] tap;
  always_comb begin
    lsum = 0;
    for (int i = 0; i < 32; i++) lsum += int'(lane_out[i*4 +: 4]);
    cur = {lane_valid, 9'(lsum)};
  end
  always @(posedge clk) begin
    dl[1] <= cur;
    dl[2] <= dl[1];
    dl[3] <= dl[2];
    junk <= 9'($urandom);
  end
  assign tap = (DP == 0) ? cur : dl[DP == 0 ? 1 : DP];
  assign psum_in = tap[9] ? tap[8:0] : junk;
  // model: job timing as cycle offsets from the accept edge, result as a plain dot product
  logic [3:0] w [32] = '{default: '0};
  logic [3:0] a [32] = '{default: '0};
  int res = 0, s_cyc = -1, now = 0;
  logic [12:0] exp_out = '0;
  logic werr = 1'b0;
  int ov_q [$];
  function automatic int kidx();
    return (s_cyc < 0) ? 0 : now - s_cyc + 1;
  endfunction
  initial forever begin : model
    int k;
    bit idle, rdy;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      s_cyc = -1;
      exp_out = '0;
      werr = 1'b0;
      for (int i = 0; i < 32; i++) w[i] = '0;
    end else begin
      k = kidx();
      idle = k == 0 || k > 5 + DP;
      rdy = idle || k == 5 + DP;
      werr = wgt_we && !idle;
      if (wgt_we && idle) w[wgt_addr] = wgt_data;
      now++;
      if (in_valid && rdy) begin
        s_cyc = now;
        res = 0;
        for (int i = 0; i < 32; i++) begin
          a[i] = in_act[i*4 +: 4];
          res += int'(w[i]) * int'(a[i]);
        end
      end
      if (kidx() == 5 + DP) exp_out = 13'(res);
    end
  end
  logic [127:0] prev_lane = '0;
  initial forever begin : compare
    int k, bb;
    bit iss, zero, skip;
    logic [127:0] g, el;
    @(negedge clk);
    k = kidx();
    iss = k >= 1 && k <= 4;
    bb = 4 - k;
    g = '0;
    zero = 1'b1;
    if (iss)
      for (int i = 0; i < 32; i++)
        if (a[i][bb]) begin
          g[i*4 +: 4] = w[i];
          zero = 1'b0;
        end
    skip = 1'b0;
`ifdef ZERO_SKIP_EN
    skip = iss && zero;
`endif
    el = !iss ? '0 : (skip ? prev_lane : g);
    chk("in_ready", in_ready, !(k >= 1 && k <= 4 + DP));
    chk("busy", busy, k >= 1 && k <= 5 + DP);
    chk("lane_valid", lane_valid, iss && !skip);
    chk("lane_out", lane_out, el);
    chk("out_valid", out_valid, k == 5 + DP);
    chk("Output", Output, exp_out);
    chk("wgt_err", wgt_err, werr);
    prev_lane = el;
    if (out_valid) ov_q.push_back(now);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int l, input int v);
    wgt_we = 1'b1;
    wgt_addr = 5'(l);
    wgt_data = 4'(v);
    tick();
    wgt_we = 1'b0;
  endtask
  task automatic run_job(output int lat);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin : stim
    int lat, n, base, seed;
    seed = 7;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_Output", Output, 0);
    rst_n = 1'b1;
    tick();
    // all-15 weights and activations: full-scale result
    for (int i = 0; i < 32; i++) wr(i, 15);
    in_act = {32{4'hf}};
    run_job(lat);
    chk("t1_latency", lat, 5 + DP);
    chk("t1_Output", Output, 7200);
    tick();
    // ten back-to-back random jobs with in_valid held
    for (int i = 0; i < 32; i++) wr(i, i % 16);
    base = ov_q.size();
    in_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      for (int i = 0; i < 32; i++) in_act[i*4 +: 4] = 4'($random(seed));
      n = 0;
      while (!in_ready && n < 20) begin
        tick();
        n++;
      end
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (ov_q.size() < base + 10 && n < 40) begin
      tick();
      n++;
    end
    tick();
    chk("t2_count", ov_q.size() - base, 10);
    for (int j = 1; j < 10; j++) chk("t2_gap", ov_q[base+j] - ov_q[base+j-1], 5 + DP);
    // weight write while busy is dropped, then applied in IDLE
    in_act = {32{4'h1}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    wr(5, 9);
    chk("t3_err", wgt_err, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("t3_Output_dropped", Output, 240);
    tick();
    wr(5, 9);
    chk("t3_noerr", wgt_err, 0);
    run_job(lat);
    chk("t3_Output_applied", Output, 244);
    tick();
    // 0101 activations: two planes are all zero
    for (int i = 0; i < 32; i++) wr(i, 3);
    in_act = {32{4'h5}};
    run_job(lat);
    chk("t5_latency", lat, 5 + DP);
    chk("t5_Output", Output, 480);
    tick();
    // unit weights and activations
    for (int i = 0; i < 32; i++) wr(i, 1);
    in_act = {32{4'h1}};
    run_job(lat);
    chk("t6_latency", lat, 5 + DP);
    chk("t6_Output", Output, 32);
    tick();
    // asynchronous reset in cycle 3 of a job
    base = ov_q.size();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_lane_valid", lane_valid, 0);
    chk("t4_lane_out", lane_out, 0);
    chk("t4_in_ready", in_ready, 1);
    chk("t4_Output", Output, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t4_in_ready_after", in_ready, 1);
    chk("t4_no_out_valid", ov_q.size() - base, 0);
    run_job(lat);
    chk("t4_latency", lat, 5 + DP);
    chk("t4_weights_cleared", Output, 0);
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
